// File: rtl/weight_fetch_ctrl.sv
// Fetch sequencer for the 5x5 binary weight preload chain: reads the five column
// words of one kernel from BRAM and aligns the chain shift enable to the BRAM latency.
module weight_fetch_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int BASE_ADDR   = 0,
  parameter int NUM_KERNELS = 64,
  parameter int BRAM_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] kernel_idx,
  input  logic              abort,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              load_weight_preload,
  output logic              busy,
  output logic              done,
  output logic              idx_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  localparam logic [ADDR_W:0]   NUM_K      = (ADDR_W+1)'(NUM_KERNELS);
  localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);
  // Bits of {en_pipe, bram_en} that must be clear before FIN so that FIN lines up with the last load.
  localparam logic [BRAM_LAT:0] DRAIN_MASK = (BRAM_LAT+1)'((1 << (BRAM_LAT-1)) - 1);

  state_t              state, state_nx;
  logic [2:0]          col, col_nx;
  logic [ADDR_W-1:0]   base_p0, base_nx, addr_nx;
  logic [BRAM_LAT-1:0] en_pipe;
  logic [BRAM_LAT:0]   en_chain;
  logic                base_ld, en_nx, busy_nx, done_nx, err_nx, err_p0, flush;
  logic                k_ok, drain_clear;

  assign en_chain            = {en_pipe, bram_en};
  assign load_weight_preload = en_pipe[BRAM_LAT-1];
  assign drain_clear         = ((en_chain & DRAIN_MASK) == '0);
  assign k_ok                = ({1'b0, kernel_idx} < NUM_K);
  assign base_nx             = BASE + (kernel_idx << 2) + kernel_idx;

  always_comb begin
    state_nx = state;
    col_nx   = col;
    base_ld  = 1'b0;
    en_nx    = 1'b0;
    addr_nx  = bram_addr;
    busy_nx  = 1'b0;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    flush    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (k_ok) begin
            state_nx = ISSUE;
            col_nx   = 3'd0;
            base_ld  = 1'b1;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      ISSUE: begin
        en_nx   = 1'b1;
        addr_nx = base_p0 + ADDR_W'(col);
        busy_nx = 1'b1;
        col_nx  = col + 3'd1;
        if (col == 3'd4) state_nx = DRAIN;
      end
      DRAIN: begin
        busy_nx = 1'b1;
        if (drain_clear) state_nx = FIN;
      end
      FIN: begin
        done_nx  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Abort overrides everything outside IDLE, including a start in the same cycle.
    if (abort && state != IDLE) begin
      state_nx = IDLE;
      col_nx   = 3'd0;
      en_nx    = 1'b0;
      addr_nx  = bram_addr;
      busy_nx  = 1'b0;
      done_nx  = 1'b0;
      flush    = 1'b1;
    end
  end

  // p0: FSM state, column counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      col       <= 3'd0;
      bram_en   <= 1'b0;
      bram_addr <= '0;
      en_pipe   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_p0    <= 1'b0;
      idx_err   <= 1'b0;
    end else begin
      state     <= state_nx;
      col       <= col_nx;
      bram_en   <= en_nx;
      bram_addr <= addr_nx;
      en_pipe   <= flush ? '0 : en_chain[BRAM_LAT-1:0];
      busy      <= busy_nx;
      done      <= done_nx;
      err_p0    <= err_nx;
      idx_err   <= err_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (base_ld) base_p0 <= base_nx;
  end

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Scoreboard bench for weight_fetch_ctrl: expected addresses, done/err cycles and
// final chain contents are queued at stimulus time and compared on DUT output.
module tb_weight_fetch_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  logic       start0, abort0, bram_en0, load0, busy0, done0, err0;
  logic [9:0] kidx0, bram_addr0;
  logic       start1, abort1, bram_en1, load1, busy1, done1, err1;
  logic [9:0] kidx1, bram_addr1;
  logic       start2, abort2, bram_en2, load2, busy2, done2, err2;
  logic [3:0] kidx2, bram_addr2;

  weight_fetch_ctrl #(.ADDR_W(10), .BASE_ADDR(0), .NUM_KERNELS(64), .BRAM_LAT(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .kernel_idx(kidx0), .abort(abort0),
    .bram_en(bram_en0), .bram_addr(bram_addr0), .load_weight_preload(load0),
    .busy(busy0), .done(done0), .idx_err(err0));

  weight_fetch_ctrl #(.ADDR_W(10), .BASE_ADDR(0), .NUM_KERNELS(64), .BRAM_LAT(3)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .kernel_idx(kidx1), .abort(abort1),
    .bram_en(bram_en1), .bram_addr(bram_addr1), .load_weight_preload(load1),
    .busy(busy1), .done(done1), .idx_err(err1));

  weight_fetch_ctrl #(.ADDR_W(4), .BASE_ADDR(0), .NUM_KERNELS(4), .BRAM_LAT(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .kernel_idx(kidx2), .abort(abort2),
    .bram_en(bram_en2), .bram_addr(bram_addr2), .load_weight_preload(load2),
    .busy(busy2), .done(done2), .idx_err(err2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;
  int addr_q[$];
  int done_q[$];
  int base_q[$];
  int err_q[$];
  int load_cnt = 0;
  int busy_lo  = 1;
  int busy_hi  = 0;

  // BRAM model word(a) = a[4:0], one cycle latency, feeding a 5-row shift chain
  logic [4:0] dout;
  logic [4:0] row [5];

  always @(posedge clk) begin
    if (bram_en0) dout <= bram_addr0[4:0];
    if (load0) for (int r = 0; r < 5; r++) row[r] <= {row[r][3:0], dout[r]};
  end

  task automatic chk(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [24:0] exp_chain(input int base);
    logic [24:0] e;
    int w;
    e = '0;
    for (int j = 0; j < 5; j++) begin
      w = base + j;
      for (int r = 0; r < 5; r++) e[r*5 + (4-j)] = 1'((w >> r) & 1);
    end
    return e;
  endfunction

  function automatic logic [24:0] act_chain();
    logic [24:0] a;
    for (int r = 0; r < 5; r++) a[r*5 +: 5] = row[r];
    return a;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (bram_en0) begin
        if (addr_q.size() == 0) chk("addr_extra", bram_addr0, -1);
        else chk("addr", bram_addr0, addr_q.pop_front());
      end
      if (load0) load_cnt++;
      if (done0) begin
        if (done_q.size() == 0) chk("done_extra", cyc, -1);
        else begin
          chk("done_cyc", cyc, done_q.pop_front());
          chk("chain", act_chain(), exp_chain(base_q.pop_front()));
        end
      end
      if (err0) begin
        if (err_q.size() == 0) chk("err_extra", cyc, -1);
        else chk("err_cyc", cyc, err_q.pop_front());
      end
      chk("busy", busy0, (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) tick();
  endtask

  task automatic start_fetch(input int k, output int t0);
    t0     = cyc + 1;
    kidx0  = 10'(k);
    start0 = 1'b1;
    if (k < 64) begin
      for (int j = 0; j < 5; j++) addr_q.push_back((k*5 + j) % 1024);
      done_q.push_back(t0 + 7);
      base_q.push_back(k*5);
      busy_lo = t0 + 1;
      busy_hi = t0 + 6;
    end else begin
      err_q.push_back(t0 + 1);
    end
    tick();
    start0 = 1'b0;
  endtask

  task automatic flush_model();
    addr_q.delete();
    done_q.delete();
    base_q.delete();
    err_q.delete();
  endtask

  task automatic chk_drained(input string tag);
    chk({tag, "_addr_left"}, addr_q.size(), 0);
    chk({tag, "_done_left"}, done_q.size(), 0);
  endtask

  initial begin
    int t0, t1;
    rst_n  = 1'b0;
    start0 = 1'b0; abort0 = 1'b0; kidx0 = '0;
    start1 = 1'b0; abort1 = 1'b0; kidx1 = '0;
    start2 = 1'b0; abort2 = 1'b0; kidx2 = '0;
    #1;
    chk("rst_outs", {bram_en0, load0, busy0, done0, err0}, 0);
    chk("rst_addr", bram_addr0, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // basic fetch, kernel 3
    load_cnt = 0;
    start_fetch(3, t0);
    wait_until(t0 + 10);
    chk("k3_loads", load_cnt, 5);
    chk_drained("k3");

    // back-to-back: second start in the done cycle
    load_cnt = 0;
    start_fetch(0, t0);
    wait_until(t0 + 7);
    start_fetch(1, t1);
    wait_until(t1 + 10);
    chk("b2b_loads", load_cnt, 10);
    chk_drained("b2b");

    // abort in cycle 3 together with a start that must be dropped
    load_cnt = 0;
    start_fetch(6, t0);
    wait_until(t0 + 3);
    abort0 = 1'b1; start0 = 1'b1; kidx0 = 10'd9;
    tick();
    abort0 = 1'b0; start0 = 1'b0;
    flush_model();
    busy_hi = t0 + 3;
    wait_until(t0 + 14);
    chk("abort_loads", load_cnt, 2);
    chk_drained("abort");

    // abort while idle does not block a start
    load_cnt = 0;
    abort0 = 1'b1;
    start_fetch(7, t0);
    abort0 = 1'b0;
    wait_until(t0 + 10);
    chk("idle_abort_loads", load_cnt, 5);
    chk_drained("idle_abort");

    // out-of-range then last legal kernel
    load_cnt = 0;
    start_fetch(64, t0);
    wait_until(t0 + 5);
    chk("idx_err_left", err_q.size(), 0);
    start_fetch(63, t0);
    wait_until(t0 + 10);
    chk("k63_loads", load_cnt, 5);
    chk_drained("k63");

    // start while busy is ignored
    load_cnt = 0;
    start_fetch(4, t0);
    wait_until(t0 + 2);
    start0 = 1'b1; kidx0 = 10'd9;
    tick();
    start0 = 1'b0;
    wait_until(t0 + 14);
    chk("ignored_loads", load_cnt, 5);
    chk_drained("ignored");

    // asynchronous reset mid-fetch
    start_fetch(5, t0);
    wait_until(t0 + 4);
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", {bram_en0, load0, busy0, done0, err0}, 0);
    chk("midrst_addr", bram_addr0, 0);
    flush_model();
    busy_lo = 1; busy_hi = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    load_cnt = 0;
    start_fetch(2, t0);
    wait_until(t0 + 10);
    chk("post_rst_loads", load_cnt, 5);
    chk_drained("post_rst");

    // BRAM_LAT = 3 timing
    t0 = cyc + 1;
    kidx1 = 10'd0; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      wait_until(t0 + n);
      #3;
      chk("l3_load", load1, (n >= 4 && n <= 8) ? 1 : 0);
      chk("l3_done", done1, (n == 9) ? 1 : 0);
      chk("l3_busy", busy1, (n <= 8) ? 1 : 0);
    end
    chk("l3_idle", {bram_en1, err1}, 0);
    chk("l3_addr_hold", bram_addr1, 4);

    // ADDR_W = 4 address wrap
    t0 = cyc + 1;
    kidx2 = 4'd3; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      wait_until(t0 + n);
      #3;
      chk("w_en", bram_en2, 1);
      chk("w_addr", bram_addr2, (15 + n - 1) % 16);
    end
    wait_until(t0 + 7);
    #3;
    chk("w_done", {done2, busy2, load2, err2}, 4'b1000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
